// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: the branch requester always wins a slot, remaining slots are
// filled round-robin. Grants/stalls are same-cycle; slot selects are registered.
module cdb_arbiter #(
   parameter int unsigned NUM_REQ  = 8,
   parameter int unsigned NUM_CDB  = 3,
   parameter int unsigned PRIO_IDX = 7,
   parameter int unsigned IW       = $clog2(NUM_REQ)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       cdb_hold,
   input  logic                       flush,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         stall,
   output logic [NUM_CDB-1:0]         slot_valid,
   output logic [NUM_CDB-1:0][IW-1:0] slot_idx,
   output logic [IW-1:0]              rr_ptr
);

   localparam int unsigned SW = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

   logic [NUM_CDB-1:0]         slot_valid_q, slot_valid_d;
   logic [NUM_CDB-1:0][IW-1:0] slot_idx_q, slot_idx_d;
   logic [IW-1:0]              rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]         scan_grant;
   logic [NUM_CDB-1:0]         scan_vld;
   logic [NUM_CDB-1:0][IW-1:0] scan_idx;
   logic                       scan_any;
   logic [31:0]                scan_last;
   logic [31:0]                cand;
   logic [IW-1:0]              cand_i;
   logic [SW-1:0]              slot_i;
   int unsigned                n_gnt;
   logic                       arb_en;

   // Branch requester takes the top slot; the rest fill downward in rotating order.
   always_comb begin
      scan_grant = '0;
      scan_vld   = '0;
      scan_idx   = '0;
      scan_any   = 1'b0;
      scan_last  = '0;
      cand       = '0;
      cand_i     = '0;
      slot_i     = '0;
      n_gnt      = 0;
      if (req[PRIO_IDX]) begin
         scan_grant[PRIO_IDX] = 1'b1;
         scan_vld[NUM_CDB-1]  = 1'b1;
         scan_idx[NUM_CDB-1]  = IW'(PRIO_IDX);
         n_gnt                = 1;
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         cand   = (32'(rr_ptr_q) + j) % NUM_REQ;
         cand_i = cand[IW-1:0];
         if (cand != PRIO_IDX && req[cand_i] && n_gnt < NUM_CDB) begin
            slot_i             = SW'(NUM_CDB - 1 - n_gnt);
            scan_grant[cand_i] = 1'b1;
            scan_vld[slot_i]   = 1'b1;
            scan_idx[slot_i]   = cand_i;
            scan_any           = 1'b1;
            scan_last          = cand;
            n_gnt              = n_gnt + 1;
         end
      end
   end

   always_comb begin
      arb_en       = reset & ~cdb_hold & ~flush;
      grant        = arb_en ? scan_grant : '0;
      stall        = (reset && !flush) ? (req & ~grant) : '0;
      slot_valid_d = arb_en ? scan_vld : '0;
      slot_idx_d   = arb_en ? scan_idx : '0;
      rr_ptr_d     = rr_ptr_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (arb_en && scan_any) begin
         rr_ptr_d = IW'((scan_last + 1) % NUM_REQ);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_valid_q <= '0;
         slot_idx_q   <= '0;
         rr_ptr_q     <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_idx_q   <= slot_idx_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign slot_valid = slot_valid_q;
   assign slot_idx   = slot_idx_q;
   assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios, a registered-output scoreboard,
// per-cycle invariants and a starvation bound under random traffic.
module tb_cdb_arbiter;

   localparam int unsigned NR = 8;
   localparam int unsigned NC = 3;
   localparam int unsigned PI = 7;

   typedef struct {
      logic [2:0]      sv;
      logic [2:0][2:0] si;
      logic [2:0]      rr;
      logic            flushed;
   } exp_t;

   logic            clk;
   logic            reset;
   logic [7:0]      req;
   logic            cdb_hold;
   logic            flush;
   logic [7:0]      grant;
   logic [7:0]      stall;
   logic [2:0]      slot_valid;
   logic [2:0][2:0] slot_idx;
   logic [2:0]      rr_ptr;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic        mon_ok;
   logic [2:0]  m_rr;
   logic [7:0]  exp_grant;
   logic [7:0]  exp_stall;
   int unsigned wt[8];

   cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .PRIO_IDX(PI)) dut (
      .clock(clk), .reset(reset), .req(req), .cdb_hold(cdb_hold), .flush(flush),
      .grant(grant), .stall(stall), .slot_valid(slot_valid), .slot_idx(slot_idx),
      .rr_ptr(rr_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step(input logic [7:0] r, input logic h, input logic f,
                             output logic [7:0] g, output exp_t e);
      int unsigned order[$];
      int unsigned last;
      int unsigned ix;
      last      = 8;
      g         = '0;
      e.sv      = '0;
      e.si      = '0;
      e.flushed = f;
      e.rr      = f ? 3'd0 : m_rr;
      if (!f && !h) begin
         if (r[7]) order.push_back(7);
         for (int unsigned j = 0; j < 8; j++) begin
            ix = (m_rr + j) % 8;
            if (ix != 7 && r[ix]) order.push_back(ix);
         end
         foreach (order[k]) begin
            if (k < 3) begin
               g[order[k]] = 1'b1;
               e.sv[2-k]   = 1'b1;
               e.si[2-k]   = 3'(order[k]);
               if (order[k] != 7) last = order[k];
            end
         end
         if (last != 8) e.rr = 3'((last + 1) % 8);
      end
   endtask

   task automatic apply(input logic [7:0] r, input logic h, input logic f);
      exp_t e;
      @(negedge clk);
      req = r; cdb_hold = h; flush = f;
      model_step(r, h, f, exp_grant, e);
      exp_stall = f ? 8'h00 : (r & ~exp_grant);
      sb.push_back(e);
      m_rr = e.rr;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; req = '0; cdb_hold = 1'b0; flush = 1'b0;
      sb.delete();
      m_rr = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Registered outputs against the model, one cycle after each drive.
   always @(posedge clk) begin
      #1;
      if (reset && sb.size() != 0) begin
         mon_e  = sb.pop_front();
         mon_ok = (slot_valid === mon_e.sv) && (rr_ptr === mon_e.rr);
         for (int k = 0; k < 3; k++)
            if (mon_e.sv[k] && slot_idx[k] !== mon_e.si[k]) mon_ok = 1'b0;
         if (mon_e.flushed && slot_idx !== '0) mon_ok = 1'b0;
         n_checks++;
         if (mon_ok) n_pass++;
         else $display("FAIL sb_slots: got valid=%b idx=%h rr=%0d want valid=%b idx=%h rr=%0d",
                       slot_valid, slot_idx, rr_ptr, mon_e.sv, mon_e.si, mon_e.rr);
      end
   end

   always @(negedge clk) begin
      #2;
      if (!reset) begin
         for (int i = 0; i < 8; i++) wt[i] = 0;
      end else begin
         n_checks++;
         if ((grant & ~req) !== 8'h00) $display("FAIL inv_subset: grant=%h req=%h", grant, req);
         else n_pass++;
         n_checks++;
         if ($countones(grant) > 3) $display("FAIL inv_count: grant=%h want <=3 bits", grant);
         else n_pass++;
         n_checks++;
         if ((grant & stall) !== 8'h00) $display("FAIL inv_disjoint: grant=%h stall=%h", grant, stall);
         else n_pass++;
         n_checks++;
         if (stall !== (flush ? 8'h00 : (req & ~grant)))
            $display("FAIL inv_stall: got %h want %h", stall, flush ? 8'h00 : (req & ~grant));
         else n_pass++;
         n_checks++;
         mon_ok = 1'b1;
         for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 3; b++)
               if (slot_valid[a] && slot_valid[b] && slot_idx[a] == slot_idx[b]) mon_ok = 1'b0;
         if (!mon_ok) $display("FAIL inv_unique: valid=%b idx=%h want distinct", slot_valid, slot_idx);
         else n_pass++;
         for (int i = 0; i < 8; i++) begin
            if (flush || !req[i]) wt[i] = 0;
            else if (!cdb_hold) begin
               if (grant[i]) begin
                  n_checks++;
                  if (wt[i] <= 3) n_pass++;
                  else $display("FAIL starve_%0d: waited %0d want <=3", i, wt[i]);
                  wt[i] = 0;
               end else begin
                  wt[i]++;
                  if (wt[i] > 3) begin
                     n_checks++;
                     $display("FAIL starve_%0d: waited %0d want <=3", i, wt[i]);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; req = 8'hFF; cdb_hold = 1'b0; flush = 1'b0;
      sb.delete(); m_rr = '0;
      #1;
      n_checks++;
      if ({grant, stall} !== 16'h0000) $display("FAIL reset_gs: got %h/%h want 00/00", grant, stall);
      else n_pass++;
      n_checks++;
      if (slot_valid !== 3'b000 || slot_idx !== '0 || rr_ptr !== 3'd0)
         $display("FAIL reset_regs: got v=%b i=%h rr=%0d want 0/0/0", slot_valid, slot_idx, rr_ptr);
      else n_pass++;
      @(negedge clk);
      req = '0; reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      apply(8'h01, 1'b0, 1'b0);
      n_checks++;
      if ({grant, stall} !== {8'h01, 8'h00}) $display("FAIL single_gs: got %h/%h want 01/00", grant, stall);
      else n_pass++;
      apply(8'h29, 1'b0, 1'b0);
      n_checks++;
      if (slot_valid !== 3'b100 || slot_idx[2] !== 3'd0 || rr_ptr !== 3'd1)
         $display("FAIL single_regs: got v=%b i2=%0d rr=%0d want 100/0/1", slot_valid, slot_idx[2], rr_ptr);
      else n_pass++;
      n_checks++;
      if ({grant, stall} !== {8'h29, 8'h00}) $display("FAIL undersub_gs: got %h/%h want 29/00", grant, stall);
      else n_pass++;
   endtask

   task automatic test_rr_sequence();
      do_reset();
      apply(8'h7F, 1'b0, 1'b0);
      n_checks++;
      if ({grant, stall} !== {8'h07, 8'h78}) $display("FAIL rr1_gs: got %h/%h want 07/78", grant, stall);
      else n_pass++;
      apply(8'h7F, 1'b0, 1'b0);
      n_checks++;
      if (rr_ptr !== 3'd3 || slot_idx !== {3'd0, 3'd1, 3'd2} || grant !== 8'h38)
         $display("FAIL rr2: got rr=%0d idx=%h g=%h want 3/%h/38", rr_ptr, slot_idx, grant, {3'd0, 3'd1, 3'd2});
      else n_pass++;
      apply(8'h7F, 1'b0, 1'b0);
      n_checks++;
      if (rr_ptr !== 3'd6 || slot_idx !== {3'd3, 3'd4, 3'd5} || grant !== 8'h43)
         $display("FAIL rr3: got rr=%0d idx=%h g=%h want 6/%h/43", rr_ptr, slot_idx, grant, {3'd3, 3'd4, 3'd5});
      else n_pass++;
      apply(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (rr_ptr !== 3'd2 || slot_idx !== {3'd6, 3'd0, 3'd1})
         $display("FAIL rr_wrap: got rr=%0d idx=%h want 2/%h", rr_ptr, slot_idx, {3'd6, 3'd0, 3'd1});
      else n_pass++;
   endtask

   task automatic test_prio_wrap();
      do_reset();
      apply(8'h07, 1'b0, 1'b0);
      apply(8'h83, 1'b0, 1'b0);
      n_checks++;
      if (rr_ptr !== 3'd3 || {grant, stall} !== {8'h83, 8'h00})
         $display("FAIL prio_gs: got rr=%0d %h/%h want 3 83/00", rr_ptr, grant, stall);
      else n_pass++;
      apply(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (slot_valid !== 3'b111 || slot_idx !== {3'd7, 3'd0, 3'd1} || rr_ptr !== 3'd2)
         $display("FAIL prio_slots: got v=%b idx=%h rr=%0d want 111/%h/2", slot_valid, slot_idx, rr_ptr,
                  {3'd7, 3'd0, 3'd1});
      else n_pass++;
   endtask

   task automatic test_hold();
      do_reset();
      apply(8'h03, 1'b0, 1'b0);
      apply(8'hFF, 1'b1, 1'b0);
      n_checks++;
      if ({grant, stall} !== {8'h00, 8'hFF} || rr_ptr !== 3'd2)
         $display("FAIL hold_gs: got %h/%h rr=%0d want 00/FF rr=2", grant, stall, rr_ptr);
      else n_pass++;
      apply(8'hFF, 1'b0, 1'b0);
      n_checks++;
      if (slot_valid !== 3'b000 || rr_ptr !== 3'd2)
         $display("FAIL hold_regs: got v=%b rr=%0d want 000/2", slot_valid, rr_ptr);
      else n_pass++;
      n_checks++;
      if ({grant, stall} !== {8'h8C, 8'h73}) $display("FAIL hold_resume: got %h/%h want 8C/73", grant, stall);
      else n_pass++;
      apply(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (rr_ptr !== 3'd4 || slot_idx !== {3'd7, 3'd2, 3'd3})
         $display("FAIL hold_after: got rr=%0d idx=%h want 4/%h", rr_ptr, slot_idx, {3'd7, 3'd2, 3'd3});
      else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      apply(8'h1F, 1'b0, 1'b0);
      apply(8'h18, 1'b0, 1'b0);
      apply(8'hFF, 1'b0, 1'b1);
      n_checks++;
      if (rr_ptr !== 3'd5 || {grant, stall} !== 16'h0000)
         $display("FAIL flush_gs: got rr=%0d %h/%h want 5 00/00", rr_ptr, grant, stall);
      else n_pass++;
      apply(8'hFF, 1'b1, 1'b1);
      n_checks++;
      if (slot_valid !== 3'b000 || slot_idx !== '0 || rr_ptr !== 3'd0)
         $display("FAIL flush_regs: got v=%b idx=%h rr=%0d want 0/0/0", slot_valid, slot_idx, rr_ptr);
      else n_pass++;
      n_checks++;
      if ({grant, stall} !== 16'h0000) $display("FAIL flush_over_hold: got %h/%h want 00/00", grant, stall);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(8'hFF, 1'b0, 1'b0);
      apply(8'hFF, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      sb.delete();
      m_rr = '0;
      #1;
      n_checks++;
      if (slot_valid !== 3'b000 || slot_idx !== '0 || rr_ptr !== 3'd0 || {grant, stall} !== 16'h0000)
         $display("FAIL async_reset: got v=%b idx=%h rr=%0d g=%h s=%h want all 0",
                  slot_valid, slot_idx, rr_ptr, grant, stall);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       h, f;
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         r = 8'($urandom) | 8'($urandom);
         h = ($urandom_range(0, 9) == 0);
         f = ($urandom_range(0, 31) == 0);
         apply(r, h, f);
         n_checks++;
         if ({grant, stall} !== {exp_grant, exp_stall})
            $display("FAIL rand_gs: req=%h h=%b f=%b got %h/%h want %h/%h", r, h, f, grant, stall,
                     exp_grant, exp_stall);
         else n_pass++;
      end
      apply(8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0; req = '0; cdb_hold = 1'b0; flush = 1'b0; m_rr = '0;
      exp_grant = '0; exp_stall = '0;
      test_reset();
      test_single();
      test_rr_sequence();
      test_prio_wrap();
      test_hold();
      test_flush();
      test_async_reset();
      test_random();
      for (int i = 0; i < 5 && sb.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      n_checks++;
      if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
